// File: rtl/fpu_pkg.sv
// Shared FPU definitions: controller states, IEEE-754 single constants and
// a field view of a packed single-precision word.
// Used by the iterative divider and by the operand classifier.
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIV,
        ROUND,
        OUT
    } state_t;

    localparam int          EXP_BIAS    = 127;
    localparam int          Q_BITS      = 26;
    localparam logic [31:0] INF_POS     = 32'h7F80_0000;
    localparam logic [31:0] NAN_DEFAULT = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp_fields_t;

endpackage

// File: rtl/fpu_classify.sv
// Purpose : classify one IEEE-754 single operand (zero/inf/NaN) and expose sign and significand.
// Latency : combinational.
// Backpressure: none (pure function of operand).
// Ports   : operand in; is_zero, is_inf, is_nan, sign, signif (24-bit, hidden bit included) out.
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [31:0] operand,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        sign,
    output logic [23:0] signif
);

    fp_fields_t f;

    assign f = operand;

    // exp==0 covers true zero and denormals; both are flushed to zero.
    assign is_zero = (f.exp == 8'h00);
    assign is_inf  = (f.exp == 8'hFF) && (f.frac == 23'd0);
    assign is_nan  = (f.exp == 8'hFF) && (f.frac != 23'd0);
    assign sign    = f.sign;
    assign signif  = {~is_zero, f.frac};

endmodule

// File: rtl/fpu_div_iter.sv
// Purpose : iterative single-precision divider c = a / b, restoring radix-2, round-to-nearest-even.
// Latency : result valid 28 cycles after the joint a/b accept, fixed for every operand class.
// Backpressure: one operation in flight; treadys low until the result is taken, result held while tready low.
// Ports   : aclk/aresetn (sync, active-low); s_axis_a_*/s_axis_b_* operand slaves; m_axis_result_* master.
module fpu_div_iter
    import fpu_pkg::*;
#(
    parameter logic [31:0] NAN_PAT = NAN_DEFAULT
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    output logic        s_axis_b_tready,
    input  logic [31:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready,
    output logic [31:0] m_axis_result_tdata
);

    state_t             state, state_nxt;
    logic               tready_q;
    logic [31:0]        a_q, b_q, tdata_q;
    logic               sign_q, nan_q, inf_q, zero_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        mb_q;
    logic [25:0]        rem_q, q_q;
    logic [4:0]         cnt_q;

    logic               za, ia, na, sa, zb, ib, nb, sb;
    logic [23:0]        sig_a, sig_b;

    fpu_classify u_cls_a (
        .operand (a_q), .is_zero (za), .is_inf (ia), .is_nan (na), .sign (sa), .signif (sig_a)
    );

    fpu_classify u_cls_b (
        .operand (b_q), .is_zero (zb), .is_inf (ib), .is_nan (nb), .sign (sb), .signif (sig_b)
    );

    // Accept only when both operands are offered while the registered ready is up.
    logic accept;
    assign accept = (state == IDLE) && tready_q && s_axis_a_tvalid && s_axis_b_tvalid;

    // ---- state register ----
    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // ---- next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = UNPACK;
            UNPACK:  state_nxt = DIV;
            DIV:     if (cnt_q == 5'(Q_BITS - 1)) state_nxt = ROUND;
            ROUND:   state_nxt = OUT;
            OUT:     if (m_axis_result_tready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- outputs ----
    always_comb begin
        s_axis_a_tready      = tready_q;
        s_axis_b_tready      = tready_q;
        m_axis_result_tvalid = (state == OUT);
        m_axis_result_tdata  = tdata_q;
    end

    // ---- unpack: pre-normalise so the quotient lands in [1,2) ----
    logic              ma_lt;
    logic signed [9:0] exp_un;
    logic [25:0]       rem_init;

    always_comb begin
        ma_lt    = (sig_a < sig_b);
        exp_un   = {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'(EXP_BIAS) - {9'd0, ma_lt};
        rem_init = ma_lt ? {1'b0, sig_a, 1'b0} : {2'b00, sig_a};
    end

    // ---- one restoring step ----
    logic        q_bit;
    logic [25:0] rem_step;

    always_comb begin
        q_bit    = (rem_q >= {2'b00, mb_q});
        rem_step = q_bit ? (rem_q - {2'b00, mb_q}) : rem_q;
    end

    // ---- rounding and final packing ----
    logic              inc, carry;
    logic [22:0]       frac_f;
    logic signed [9:0] exp_f;
    logic [31:0]       result;

    always_comb begin
        inc    = q_q[1] & (q_q[0] | (|rem_q) | q_q[2]);
        // All-ones mantissa plus one wraps the fraction to zero and bumps the exponent.
        carry  = inc & (&q_q[25:2]);
        frac_f = q_q[24:2] + {22'd0, inc};
        exp_f  = carry ? (exp_q + 10'sd1) : exp_q;

        if (nan_q)                   result = NAN_PAT;
        else if (inf_q)              result = INF_POS | {sign_q, 31'd0};
        else if (zero_q)             result = {sign_q, 31'd0};
        else if (exp_f >= 10'sd255)  result = INF_POS | {sign_q, 31'd0};
        else if (exp_f <= 10'sd0)    result = {sign_q, 31'd0};
        else                         result = {sign_q, exp_f[7:0], frac_f};
    end

    // ---- datapath ----
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tready_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            tdata_q  <= '0;
            sign_q   <= 1'b0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            exp_q    <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
        end else begin
            tready_q <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q <= s_axis_a_tdata;
                        b_q <= s_axis_b_tdata;
                    end
                end
                UNPACK: begin
                    sign_q <= sa ^ sb;
                    nan_q  <= na | nb | (za & zb) | (ia & ib);
                    inf_q  <= ia | zb;
                    zero_q <= za | ib;
                    exp_q  <= exp_un;
                    mb_q   <= sig_b;
                    rem_q  <= rem_init;
                    q_q    <= '0;
                    cnt_q  <= '0;
                end
                DIV: begin
                    q_q   <= {q_q[24:0], q_bit};
                    rem_q <= {rem_step[24:0], 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                end
                ROUND: tdata_q <= result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_div_iter.sv
module tb_fpu_div_iter;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        a_vld = 1'b0, b_vld = 1'b0, m_rdy = 1'b1;
    logic [31:0] a_dat = '0, b_dat = '0;
    logic        a_rdy, b_rdy, m_vld;
    logic [31:0] m_dat;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    fpu_div_iter #(.NAN_PAT(32'h7FC0_0000)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_a_tvalid      (a_vld),
        .s_axis_a_tready      (a_rdy),
        .s_axis_a_tdata       (a_dat),
        .s_axis_b_tvalid      (b_vld),
        .s_axis_b_tready      (b_rdy),
        .s_axis_b_tdata       (b_dat),
        .m_axis_result_tvalid (m_vld),
        .m_axis_result_tready (m_rdy),
        .m_axis_result_tdata  (m_dat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: real-valued division, then round the exact-enough double to 24 bits.
    function automatic real to_real(input logic [31:0] x);
        logic [63:0] d;
        d = {1'b0, 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s, za, zb, ia, ib, na, nb;
        real         q;
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        s  = a[31] ^ b[31];
        za = (a[30:23] == 8'd0);
        zb = (b[30:23] == 8'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC0_0000;
        if (ia || zb) return {s, 8'hFF, 23'd0};
        if (za || ib) return {s, 31'd0};
        q = to_real(a) / to_real(b);
        d = $realtobits(q);
        e = int'(d[62:52]) - 1023 + 127;
        m = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = 25'h080_0000;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int          k;
        logic [31:0] r;
        k = $urandom_range(0, 11);
        r = $urandom;
        case (k)
            0: r[30:23] = 8'd0;
            1: r[30:0]  = {8'hFF, 23'd0};
            2: begin r[30:23] = 8'hFF; r[22] = 1'b1; end
            3: r[30:23] = 8'($urandom_range(1, 4));
            4: r[30:23] = 8'($urandom_range(250, 254));
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    // One full transaction; hold>0 keeps result tready low for that many cycles after tvalid.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int hold);
        int          lat;
        logic [31:0] held;
        check({tag, "/rdy_in"}, {30'd0, a_rdy, b_rdy}, 32'd3);
        a_vld = 1'b1; b_vld = 1'b1; a_dat = a; b_dat = b;
        m_rdy = (hold == 0);
        @(posedge aclk); #1;
        a_vld = 1'b0; b_vld = 1'b0; a_dat = $urandom; b_dat = $urandom;
        check({tag, "/rdy_busy"}, {30'd0, a_rdy, b_rdy}, 32'd0);
        lat = 0;
        while (!m_vld && lat < 40) begin
            @(posedge aclk); #1;
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'd28);
        check({tag, "/data"}, m_dat, expv);
        held = m_dat;
        for (int i = 0; i < hold; i++) begin
            a_vld = (i == 1);
            @(posedge aclk); #1;
            check({tag, "/hold_vld"}, 32'(m_vld), 32'd1);
            check({tag, "/hold_dat"}, m_dat, held);
            check({tag, "/hold_rdy"}, {30'd0, a_rdy, b_rdy}, 32'd0);
        end
        a_vld = 1'b0;
        m_rdy = 1'b1;
        @(posedge aclk); #1;
        check({tag, "/vld_drop"}, 32'(m_vld), 32'd0);
        check({tag, "/rdy_back"}, {30'd0, a_rdy, b_rdy}, 32'd3);
    endtask

    initial begin
        int          seen;
        logic [31:0] ra, rb;

        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        check("rst/vld", 32'(m_vld), 32'd0);
        check("rst/dat", m_dat, 32'd0);
        check("rst/rdy", {30'd0, a_rdy, b_rdy}, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("rst/rdy_rise", {30'd0, a_rdy, b_rdy}, 32'd3);

        // A lone tvalid is never consumed
        a_vld = 1'b1; a_dat = 32'h4080_0000;
        repeat (3) begin
            @(posedge aclk); #1;
            check("lone_a/rdy", {30'd0, a_rdy, b_rdy}, 32'd3);
        end
        a_vld = 1'b0; b_vld = 1'b1; b_dat = 32'h0000_0000;
        repeat (3) begin
            @(posedge aclk); #1;
            check("lone_b/rdy", {30'd0, a_rdy, b_rdy}, 32'd3);
        end
        b_vld = 1'b0;

        // Directed values
        run_op("6/2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0);
        run_op("1/3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 0);
        run_op("-1/3",     32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 0);
        run_op("1/0",      32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 0);
        run_op("-1/0",     32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 0);
        run_op("0/0",      32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 0);
        run_op("inf/inf",  32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 0);
        run_op("nan/1",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 0);
        run_op("1/inf",    32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 0);
        run_op("ovf",      32'h7F7F_FFFF, 32'h0080_0000, 32'h7F80_0000, 0);
        run_op("unf",      32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op("denorm",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 0);

        // Backpressure for 5 cycles, with a stray a_tvalid pulse inside the window
        run_op("bp6/2",    32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5);

        // Reset in the middle of DIV
        check("mid/rdy_in", {30'd0, a_rdy, b_rdy}, 32'd3);
        a_vld = 1'b1; b_vld = 1'b1; a_dat = 32'h3F80_0000; b_dat = 32'h4040_0000;
        @(posedge aclk); #1;
        a_vld = 1'b0; b_vld = 1'b0;
        repeat (9) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check("mid/vld", 32'(m_vld), 32'd0);
        check("mid/dat", m_dat, 32'd0);
        check("mid/rdy_low", {30'd0, a_rdy, b_rdy}, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("mid/rdy_high", {30'd0, a_rdy, b_rdy}, 32'd3);
        seen = 0;
        repeat (35) begin
            @(posedge aclk); #1;
            if (m_vld) seen++;
        end
        check("mid/no_stale", 32'(seen), 32'd0);
        run_op("post6/2",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0);

        // Randomised operands against the reference model
        for (int n = 0; n < 40; n++) begin
            ra = rand_op();
            rb = rand_op();
            run_op($sformatf("rnd%0d_%h_%h", n, ra, rb), ra, rb, ref_div(ra, rb),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
